// File: rtl/maze_valid_dir_gen.sv
`default_nettype none
// ============================================================================
// maze_valid_dir_gen : scans the four neighbour tiles of a sprite snapshot in
// the maze wall ROM and registers which of left/right/up/down moves are legal.
// Revision: 1.0
// ============================================================================
module maze_valid_dir_gen #(
   parameter int MAP_W = 40,
   parameter int MAP_H = 30,
   parameter int AW    = 11
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic [9:0]    position_x,
   input  logic [8:0]    position_y,
   output logic [AW-1:0] rom_addr,
   input  logic          rom_data,
   output logic [3:0]    valid_dir,
   output logic          valid_stb
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_Q_L  = 3'd1,
      S_Q_R  = 3'd2,
      S_Q_U  = 3'd3,
      S_Q_D  = 3'd4,
      S_WAIT = 3'd5
   } state_t;

   localparam logic [6:0] c_MAP_W  = 7'(MAP_W);
   localparam logic [5:0] c_MAP_H  = 6'(MAP_H);
   localparam logic [1:0] c_SLOT_L = 2'd0;
   localparam logic [1:0] c_SLOT_R = 2'd1;
   localparam logic [1:0] c_SLOT_U = 2'd2;
   localparam logic [1:0] c_SLOT_D = 2'd3;

   state_t          r_state;
   state_t          w_next_state;
   logic [9:0]      r_px;
   logic [8:0]      r_py;
   logic [AW-1:0]   r_rom_addr;
   logic [3:0]      r_oob;
   logic [2:0]      r_wall;
   logic [3:0]      r_valid_dir;
   logic            r_valid_stb;

   logic [1:0]      w_slot;
   logic            w_slot_en;
   logic [5:0]      w_tx;
   logic [4:0]      w_ty;
   logic [6:0]      w_nx;
   logic [5:0]      w_ny;
   logic            w_edge;
   logic            w_nb_ok;
   logic [AW-1:0]   w_nb_addr;

   logic [5:0]      w_stx;
   logic [4:0]      w_sty;
   logic            w_xa;
   logic            w_ya;
   logic            w_in_map;
   logic            w_wall_d;
   logic            w_left;
   logic            w_right;
   logic            w_up;
   logic            w_down;
   logic [3:0]      w_legal;

   always_comb begin
      w_next_state = r_state;
      w_slot       = c_SLOT_L;
      w_slot_en    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (enable) begin
               w_next_state = S_Q_L;
               w_slot_en    = 1'b1;
               w_slot       = c_SLOT_L;
            end
         end
         S_Q_L: begin
            w_next_state = S_Q_R;
            w_slot_en    = 1'b1;
            w_slot       = c_SLOT_R;
         end
         S_Q_R: begin
            w_next_state = S_Q_U;
            w_slot_en    = 1'b1;
            w_slot       = c_SLOT_U;
         end
         S_Q_U: begin
            w_next_state = S_Q_D;
            w_slot_en    = 1'b1;
            w_slot       = c_SLOT_D;
         end
         S_Q_D:   w_next_state = S_WAIT;
         S_WAIT:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // The L address is issued on the capture edge, so IDLE reads the live position.
   assign w_tx = (r_state == S_IDLE) ? position_x[9:4] : r_px[9:4];
   assign w_ty = (r_state == S_IDLE) ? position_y[8:4] : r_py[8:4];

   always_comb begin
      w_nx   = {1'b0, w_tx};
      w_ny   = {1'b0, w_ty};
      w_edge = 1'b0;
      case (w_slot)
         c_SLOT_L: begin
            w_nx   = {1'b0, w_tx} - 7'd1;
            w_edge = (w_tx == 6'd0);
         end
         c_SLOT_R: w_nx = {1'b0, w_tx} + 7'd1;
         c_SLOT_U: begin
            w_ny   = {1'b0, w_ty} - 6'd1;
            w_edge = (w_ty == 5'd0);
         end
         default:  w_ny = {1'b0, w_ty} + 6'd1;
      endcase
      w_nb_ok = !w_edge && (w_nx < c_MAP_W) && (w_ny < c_MAP_H);
   end

   assign w_nb_addr = AW'(w_ny) * AW'(MAP_W) + AW'(w_nx);

   assign w_stx    = r_px[9:4];
   assign w_sty    = r_py[8:4];
   assign w_xa     = (r_px[3:0] == 4'd0);
   assign w_ya     = (r_py[3:0] == 4'd0);
   assign w_in_map = ({1'b0, w_stx} < c_MAP_W) && ({1'b0, w_sty} < c_MAP_H);
   assign w_wall_d = rom_data | r_oob[3];

   assign w_left  = w_ya & (!w_xa | ((w_stx != 6'd0) & !r_wall[0]));
   assign w_right = w_ya & (!w_xa | (({1'b0, w_stx} != c_MAP_W - 7'd1) & !r_wall[1]));
   assign w_up    = w_xa & (!w_ya | ((w_sty != 5'd0) & !r_wall[2]));
   assign w_down  = w_xa & (!w_ya | (({1'b0, w_sty} != c_MAP_H - 6'd1) & !w_wall_d));
   assign w_legal = w_in_map ? {w_down, w_up, w_right, w_left} : 4'b0000;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_px        <= '0;
         r_py        <= '0;
         r_rom_addr  <= '0;
         r_oob       <= '0;
         r_wall      <= '0;
         r_valid_dir <= 4'b0000;
         r_valid_stb <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_valid_stb <= 1'b0;
         if (r_state == S_IDLE && enable) begin
            r_px <= position_x;
            r_py <= position_y;
         end
         if (w_slot_en) begin
            r_rom_addr    <= w_nb_ok ? w_nb_addr : '0;
            r_oob[w_slot] <= !w_nb_ok;
         end else begin
            r_rom_addr <= '0;
         end
         // ROM data lags its address by one cycle; out-of-bounds slots read as wall.
         case (r_state)
            S_Q_R: r_wall[0] <= rom_data | r_oob[0];
            S_Q_U: r_wall[1] <= rom_data | r_oob[1];
            S_Q_D: r_wall[2] <= rom_data | r_oob[2];
            S_WAIT: begin
               r_valid_dir <= w_legal;
               r_valid_stb <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign rom_addr  = r_rom_addr;
   assign valid_dir = r_valid_dir;
   assign valid_stb = r_valid_stb;

endmodule
`default_nettype wire
